// File: rtl/hashed_pbp.sv
// Hashed perceptron branch predictor: single-cycle lookup against a weight table,
// with a speculative/architectural global-history pair and a one-cycle training FSM.
module hashed_pbp #(
  parameter int W_BITS      = 8,
  parameter int HIST_LEN    = 12,
  parameter int NUM_ENTRIES = 16,
  parameter int THETA       = 37,
  parameter int HASH        = 1,
  localparam int YW         = W_BITS + $clog2(HIST_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pred_valid,
  input  logic [31:0]          pred_pc,
  output logic                 pred_taken,
  output logic signed [YW-1:0] pred_y,
  output logic [HIST_LEN-1:0]  pred_ghr,
  input  logic                 upd_valid,
  output logic                 upd_ready,
  input  logic [31:0]          upd_pc,
  input  logic                 upd_taken,
  input  logic                 upd_pred_taken,
  input  logic signed [YW-1:0] upd_y,
  input  logic [HIST_LEN-1:0]  upd_ghr,
  output logic                 mispredict,
  output logic                 init_done
);

  localparam int IDX = $clog2(NUM_ENTRIES);

  typedef logic signed [W_BITS-1:0] w_t;
  typedef enum logic [1:0] {INIT, IDLE, TRAIN} state_t;

  localparam w_t              W_MAX   = w_t'((1 << (W_BITS - 1)) - 1);
  localparam w_t              W_MIN   = -W_MAX;
  localparam logic signed [YW-1:0] THETA_Y = YW'(THETA);

  state_t              state_q;
  logic [IDX-1:0]      init_cnt_q;
  logic                ready_q;
  logic                done_q;
  logic [HIST_LEN-1:0] spec_ghr_q;
  logic [HIST_LEN-1:0] arch_ghr_q;
  logic [IDX-1:0]      trn_idx_q;
  logic                trn_en_q;
  logic                trn_taken_q;
  logic [HIST_LEN-1:0] trn_ghr_q;
  w_t                  tbl_q [NUM_ENTRIES][HIST_LEN+1];

  logic                 accept;
  logic                 within_theta;
  logic [IDX-1:0]       pred_idx;
  logic [IDX-1:0]       upd_idx;
  logic signed [YW-1:0] y_raw;
  logic                 unused_bits;

  function automatic logic signed [YW-1:0] sx(input w_t w);
    return {{(YW - W_BITS){w[W_BITS-1]}}, w};
  endfunction

  function automatic w_t sat_step(input w_t w, input logic up);
    if (up) begin
      return (w == W_MAX) ? w : w + w_t'(1);
    end else begin
      return (w == W_MIN) ? w : w - w_t'(1);
    end
  endfunction

  assign pred_idx = pred_pc[IDX+1:2] ^ ((HASH != 0) ? spec_ghr_q[IDX-1:0] : '0);
  assign upd_idx  = upd_pc[IDX+1:2]  ^ ((HASH != 0) ? upd_ghr[IDX-1:0]    : '0);

  assign accept       = upd_valid & ready_q;
  assign mispredict   = accept & (upd_taken != upd_pred_taken);
  assign within_theta = (upd_y <= THETA_Y) && (upd_y >= -THETA_Y);

  assign upd_ready = ready_q;
  assign init_done = done_q;
  assign pred_ghr  = spec_ghr_q;

  always_comb begin
    y_raw = sx(tbl_q[pred_idx][HIST_LEN]);
    for (int unsigned i = 0; i < HIST_LEN; i++) begin
      y_raw = spec_ghr_q[i] ? y_raw + sx(tbl_q[pred_idx][i])
                            : y_raw - sx(tbl_q[pred_idx][i]);
    end
  end

  assign pred_y     = done_q ? y_raw : '0;
  assign pred_taken = done_q & ~y_raw[YW-1] & (y_raw != '0);

  assign unused_bits = ^{pred_pc[31:IDX+2], pred_pc[1:0], upd_pc[31:IDX+2], upd_pc[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      spec_ghr_q  <= '0;
      arch_ghr_q  <= '0;
      trn_idx_q   <= '0;
      trn_en_q    <= 1'b0;
      trn_taken_q <= 1'b0;
      trn_ghr_q   <= '0;
    end else begin
      case (state_q)
        INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == IDX'(NUM_ENTRIES - 1)) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        IDLE: begin
          if (accept) begin
            state_q     <= TRAIN;
            ready_q     <= 1'b0;
            trn_idx_q   <= upd_idx;
            trn_en_q    <= (upd_taken != upd_pred_taken) | within_theta;
            trn_taken_q <= upd_taken;
            trn_ghr_q   <= upd_ghr;
          end
        end
        TRAIN: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q    <= INIT;
          init_cnt_q <= '0;
          ready_q    <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase

      if (accept) begin
        arch_ghr_q <= {arch_ghr_q[HIST_LEN-2:0], upd_taken};
      end
      // A resolved misprediction rebuilds speculative history from the committed copy,
      // discarding any same-cycle speculative shift.
      if (mispredict) begin
        spec_ghr_q <= {arch_ghr_q[HIST_LEN-2:0], upd_taken};
      end else if (pred_valid && done_q) begin
        spec_ghr_q <= {spec_ghr_q[HIST_LEN-2:0], pred_taken};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == INIT) begin
        for (int unsigned i = 0; i <= HIST_LEN; i++) begin
          tbl_q[init_cnt_q][i] <= '0;
        end
      end else if (state_q == TRAIN && trn_en_q) begin
        for (int unsigned i = 0; i < HIST_LEN; i++) begin
          tbl_q[trn_idx_q][i] <= sat_step(tbl_q[trn_idx_q][i], trn_ghr_q[i] == trn_taken_q);
        end
        tbl_q[trn_idx_q][HIST_LEN] <= sat_step(tbl_q[trn_idx_q][HIST_LEN], trn_taken_q);
      end
    end
  end

endmodule

// File: doc/hashed_pbp.md
HASHED_PBP -- requirements
Module: hashed_pbp

Interface
REQ-001 Parameters SHALL be:
- W_BITS, default 8: signed weight width.
- HIST_LEN, default 12: global history length.
- NUM_ENTRIES, default 16: perceptron count, power of 2; IDX = log2(NUM_ENTRIES).
- THETA, default 37: training threshold.
- HASH, default 1: 1 = index PC xor history; 0 = PC only.
REQ-002 Derived: YW = W_BITS + clog2(HIST_LEN+1); HASH=1 requires HIST_LEN >= IDX.
REQ-003 Ports (clock and reset first):
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-low reset.
- pred_valid  in  1  IF-stage lookup request.
- pred_pc  in  32  IF PC.
- pred_taken  out  1  predicted direction.
- pred_y  out  YW  signed perceptron output.
- pred_ghr  out  HIST_LEN  speculative history used for this lookup; carried down the pipeline.
- upd_valid  in  1  resolved-branch update request.
- upd_ready  out  1  update accepted when high with upd_valid.
- upd_pc  in  32  branch PC.
- upd_taken  in  1  actual direction.
- upd_pred_taken  in  1  direction predicted earlier.
- upd_y  in  YW  pred_y carried from prediction.
- upd_ghr  in  HIST_LEN  pred_ghr carried from prediction.
- mispredict  out  1  history-restore/flush pulse.
- init_done  out  1  table initialised, predictor live.
REQ-004 Clock is clk; reset is rst, synchronous and active-low; no other clock or reset.

Function
REQ-005 Table SHALL hold NUM_ENTRIES x (HIST_LEN+1) signed weights, with entry HIST_LEN as bias.
REQ-006 Index SHALL be pc[IDX+1:2] xor (HASH ? ghr[IDX-1:0] : 0); prediction uses spec_ghr, update uses upd_ghr.
REQ-007 pred_y SHALL be bias + sum_i (ghr[i] ? w_i : -w_i), computed combinationally in the same cycle, sign-extended to YW with no truncation.
REQ-008 pred_taken SHALL be 1 iff pred_y > 0 (signed); pred_ghr SHALL equal spec_ghr.
REQ-009 Weights SHALL saturate in [-(2^(W_BITS-1)-1), +(2^(W_BITS-1)-1)]; an increment or decrement at a bound holds the value.
REQ-010 FSM states: INIT, IDLE, TRAIN.
- INIT: clears one entry per cycle using a counter from 0 to NUM_ENTRIES-1, then goes to IDLE.
- IDLE: on upd_valid & upd_ready, captures the update fields and goes to TRAIN.
- TRAIN: writes the entry in one cycle, then returns to IDLE.
REQ-011 upd_ready SHALL be 1 only in IDLE; init_done SHALL be 1 in IDLE and TRAIN.
REQ-012 Training SHALL occur iff upd_taken != upd_pred_taken or |upd_y| <= THETA.
- Bias: +1 if taken, -1 otherwise.
- Weight i: +1 if upd_ghr[i] == upd_taken, -1 otherwise.
- Saturation per REQ-009 applies.
- If training does not occur, TRAIN writes nothing.
REQ-013 A lookup during TRAIN SHALL read pre-write weights; new weights are visible from the next cycle.
REQ-014 arch_ghr SHALL shift left, inserting upd_taken at bit 0, on every accepted update.
REQ-015 spec_ghr SHALL shift left, inserting pred_taken, on pred_valid when init_done = 1.
REQ-016 mispredict SHALL be combinational, equal to upd_valid & upd_ready & (upd_taken != upd_pred_taken).
REQ-017 On mispredict, spec_ghr SHALL load {arch_ghr[HIST_LEN-2:0], upd_taken}; this overrides a same-cycle pred_valid shift.
REQ-018 While init_done = 0: pred_taken = 0, pred_y = 0, pred_valid is ignored, mispredict = 0.

Reset
REQ-019 With rst = 0 at a clk edge:
- State goes to INIT and the init counter to 0.
- spec_ghr and arch_ghr clear to 0.
- Any captured update is discarded.
- upd_ready, init_done, mispredict and pred_taken are 0.
REQ-020 Reset asserted mid-INIT or in TRAIN SHALL abort the operation and restart INIT from entry 0.
REQ-021 init_done SHALL rise exactly NUM_ENTRIES cycles after rst deasserts, with all weights then 0.

Verification
REQ-022 Init: release rst -> init_done = 0 for exactly 16 cycles; then pred_y = 0 and pred_taken = 0 for any PC.
REQ-023 Train: with HASH=0, give 5 updates at pc=0x40, taken=1, pred_taken=0, ghr=0xFFF, each waiting for upd_ready -> bias = 5, all w_i = 5, pred_y at 0x40 with spec_ghr=0xFFF is 65; upd_ready low in each TRAIN cycle.
REQ-024 Saturation: give 200 taken updates at one PC with upd_y = 0 -> all weights 127, never wrapping; pred_y = 1651 with YW = 12.
REQ-025 Threshold: correct prediction with upd_y = 37 -> weights change; with upd_y = 38 or -38 -> unchanged.
REQ-026 History restore: arch_ghr = 0x005, spec_ghr = 0x2AB; mispredict with upd_taken = 1 in the same cycle as pred_valid -> mispredict = 1, next spec_ghr = 0x00B, arch_ghr = 0x00B.
REQ-027 Reset mid-TRAIN: drop rst in the TRAIN cycle -> no weight write occurs, INIT restarts, init_done returns after 16 cycles.
